// File: rtl/bpu.sv
// Direct-mapped branch target buffer: combinational lookup of current_pc, one write port per clock.
// Optional macro BPU_BYPASS_EN forwards a same-cycle write to a matching lookup.
module bpu #(
   parameter int ENTRIES    = 64,
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] current_pc,
   input  logic [31:0] tag_pc,
   input  logic [31:0] next_pc,
   input  logic        bpu_w_en,
   output logic [31:0] predicted_pc
);

   localparam int TAG_W = 30 - INDEX_BITS;

   logic [ENTRIES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [TAG_W-1:0]      tag_d    [ENTRIES];
   logic [31:0]           target_q [ENTRIES];
   logic [31:0]           target_d [ENTRIES];

   logic [INDEX_BITS-1:0] wr_idx, rd_idx;
   logic [TAG_W-1:0]      wr_tag, rd_tag;
   logic                  wr_en, hit;
   logic                  unused_lsbs;

   assign wr_idx      = tag_pc[INDEX_BITS+1:2];
   assign wr_tag      = tag_pc[31:INDEX_BITS+2];
   assign rd_idx      = current_pc[INDEX_BITS+1:2];
   assign rd_tag      = current_pc[31:INDEX_BITS+2];
   assign unused_lsbs = ^tag_pc[1:0];

   // Writes are dropped while reset is held low.
   assign wr_en = bpu_w_en & reset;

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (wr_en) begin
         valid_d[wr_idx]  = 1'b1;
         tag_d[wr_idx]    = wr_tag;
         target_d[wr_idx] = next_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and target carry no reset; an entry is meaningless until its valid bit is set.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

   always_comb begin
      predicted_pc = current_pc + 32'd4;
      if (hit) begin
         predicted_pc = target_q[rd_idx];
      end
`ifdef BPU_BYPASS_EN
      if (wr_en && (wr_idx == rd_idx) && (wr_tag == rd_tag)) begin
         predicted_pc = next_pc;
      end
`else
`endif
   end

endmodule

// File: tb/tb_bpu.sv
// Self-checking bench for bpu: directed scenarios plus randomized traffic against a word-address model.
module tb_bpu;

   localparam int ENTRIES    = 64;
   localparam int INDEX_BITS = 6;

   logic        clk;
   logic        reset;
   logic [31:0] current_pc;
   logic [31:0] tag_pc;
   logic [31:0] next_pc;
   logic        bpu_w_en;
   logic [31:0] predicted_pc;

   int pass_cnt;
   int chk_cnt;

   // Model: each slot remembers the word address it was recorded for and its target.
   bit          m_vld [ENTRIES];
   logic [31:0] m_pc  [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];

   bpu #(.ENTRIES(ENTRIES), .INDEX_BITS(INDEX_BITS)) dut (
      .clk          (clk),
      .reset        (reset),
      .current_pc   (current_pc),
      .tag_pc       (tag_pc),
      .next_pc      (next_pc),
      .bpu_w_en     (bpu_w_en),
      .predicted_pc (predicted_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic logic [31:0] model_pred(input logic [31:0] pc);
      int s;
      s = slot_of(pc);
`ifdef BPU_BYPASS_EN
      if (reset && bpu_w_en && ((tag_pc & ~32'd3) == (pc & ~32'd3)))
         return next_pc;
`endif
      if (reset && m_vld[s] && m_pc[s] == (pc & ~32'd3))
         return m_tgt[s];
      return pc + 32'd4;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
   endtask

   // One rising edge, then return at the following falling edge.
   task automatic tick();
      int s;
      @(posedge clk);
      if (reset && bpu_w_en) begin
         s = slot_of(tag_pc);
         m_vld[s] = 1'b1;
         m_pc[s]  = tag_pc & ~32'd3;
         m_tgt[s] = next_pc;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_model();
      @(negedge clk);
      bpu_w_en = 1'b1; tag_pc = 32'h80; current_pc = 32'h80; next_pc = 32'h3000;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h84) $display("FAIL reset_hold_bypass: got %h want %h", predicted_pc, 32'h84);
      else pass_cnt++;
      tick();
      reset = 1'b1; bpu_w_en = 1'b0; current_pc = 32'h80;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h84) $display("FAIL reset_write_ignored: got %h want %h", predicted_pc, 32'h84);
      else pass_cnt++;
      current_pc = 32'h0;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h4) $display("FAIL reset_release_miss: got %h want %h", predicted_pc, 32'h4);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_overwrite();
      bpu_w_en = 1'b1; tag_pc = 32'h0; next_pc = 32'hC0C0C0C0; current_pc = 32'h0;
      tick();
      bpu_w_en = 1'b0;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'hC0C0C0C0) $display("FAIL overwrite_first: got %h want %h", predicted_pc, 32'hC0C0C0C0);
      else pass_cnt++;
      bpu_w_en = 1'b1; next_pc = 32'hA5A5A5AC;
      tick();
      bpu_w_en = 1'b0;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'hA5A5A5AC) $display("FAIL overwrite_second: got %h want %h", predicted_pc, 32'hA5A5A5AC);
      else pass_cnt++;
      current_pc = 32'h3;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'hA5A5A5AC) $display("FAIL low_bits_ignored: got %h want %h", predicted_pc, 32'hA5A5A5AC);
      else pass_cnt++;
   endtask

   task automatic test_alias();
      bpu_w_en = 1'b0; current_pc = 32'h100;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h104) $display("FAIL alias_miss: got %h want %h", predicted_pc, 32'h104);
      else pass_cnt++;
      bpu_w_en = 1'b1; tag_pc = 32'h100; next_pc = 32'h2000;
      tick();
      bpu_w_en = 1'b0; current_pc = 32'h0;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h4) $display("FAIL alias_evicted: got %h want %h", predicted_pc, 32'h4);
      else pass_cnt++;
      current_pc = 32'h100;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h2000) $display("FAIL alias_new_hit: got %h want %h", predicted_pc, 32'h2000);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      bpu_w_en = 1'b0; current_pc = 32'hFFFFFFFC;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h0) $display("FAIL wrap: got %h want %h", predicted_pc, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      logic [31:0] exp_pre;
`ifdef BPU_BYPASS_EN
      exp_pre = 32'h3000;
`else
      exp_pre = 32'h84;
`endif
      bpu_w_en = 1'b1; tag_pc = 32'h80; current_pc = 32'h80; next_pc = 32'h3000;
      #1;
      chk_cnt++;
      if (predicted_pc !== exp_pre) $display("FAIL same_cycle_pre: got %h want %h", predicted_pc, exp_pre);
      else pass_cnt++;
      tick();
      bpu_w_en = 1'b0;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h3000) $display("FAIL same_cycle_post: got %h want %h", predicted_pc, 32'h3000);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bpu_w_en = 1'b1; tag_pc = 32'h40; next_pc = 32'h1000; current_pc = 32'h40;
      tick();
      bpu_w_en = 1'b0;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h1000) $display("FAIL mid_reset_pre_hit: got %h want %h", predicted_pc, 32'h1000);
      else pass_cnt++;
      #1 reset = 1'b0;
      clear_model();
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h44) $display("FAIL mid_reset_async: got %h want %h", predicted_pc, 32'h44);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      current_pc = 32'h80;
      #1;
      chk_cnt++;
      if (predicted_pc !== 32'h84) $display("FAIL mid_reset_all_cleared: got %h want %h", predicted_pc, 32'h84);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_random();
      logic [31:0] exp;
      int          errs;
      errs = 0;
      for (int n = 0; n < 400; n++) begin
         bpu_w_en = ($urandom_range(0, 1) == 1);
         tag_pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         next_pc  = $urandom;
         if ($urandom_range(0, 9) == 0) current_pc = $urandom;
         else current_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) tag_pc = current_pc;
         #1;
         exp = model_pred(current_pc);
         chk_cnt++;
         if (predicted_pc !== exp) begin
            if (errs < 10) $display("FAIL random[%0d] pc=%h: got %h want %h", n, current_pc, predicted_pc, exp);
            errs++;
         end else pass_cnt++;
         tick();
      end
      bpu_w_en = 1'b0;
   endtask

   initial begin
      pass_cnt = 0; chk_cnt = 0;
      bpu_w_en = 1'b0; current_pc = '0; tag_pc = '0; next_pc = '0; reset = 1'b0;
      test_reset();
      test_overwrite();
      test_alias();
      test_wrap();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/bpu.md
BPU -- requirements
Module: bpu

Interface
REQ-001 Parameter ENTRIES, default 64, number of branch-target-buffer entries; power of two, minimum 2.
REQ-002 Parameter INDEX_BITS, default 6, equal to log2(ENTRIES).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous reset, active-low (asserted when 0).
REQ-005 current_pc  input  32  fetch PC to be predicted this cycle.
REQ-006 tag_pc  input  32  PC of a resolved control-transfer instruction whose target is being recorded.
REQ-007 next_pc  input  32  resolved target address to record for tag_pc.
REQ-008 bpu_w_en  input  1  write enable for the update port (tag_pc, next_pc).
REQ-009 predicted_pc  output  32  predicted next fetch address for current_pc.

Function
REQ-010 Storage SHALL be a direct-mapped table of ENTRIES entries, each holding a valid bit, a tag of 30-INDEX_BITS bits and a 32-bit target.
REQ-011 Index SHALL be pc[INDEX_BITS+1:2]; tag SHALL be pc[31:INDEX_BITS+2]; pc[1:0] SHALL be ignored.
REQ-012 Lookup SHALL be purely combinational from current_pc to predicted_pc, with zero-cycle latency.
REQ-013 Hit (entry valid and stored tag equals tag of current_pc): predicted_pc SHALL equal the stored target.
REQ-014 Miss: predicted_pc SHALL equal current_pc + 4, computed modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-015 On a rising clk edge with bpu_w_en=1 and reset deasserted, the entry at index(tag_pc) SHALL be written with valid=1, tag(tag_pc) and next_pc, unconditionally replacing any previous contents (including a different aliasing tag).
REQ-016 With bpu_w_en=0, the table SHALL be unchanged.
REQ-017 A write SHALL be visible to lookups from the cycle after the writing edge; same-cycle visibility is governed only by BPU_BYPASS_EN.
REQ-018 Repeated writes to the same index SHALL leave only the most recent value.
REQ-019 No next_pc value (including next_pc = tag_pc + 4) SHALL be treated specially; it is stored as given.

Reset
REQ-020 While reset=0, all valid bits SHALL be cleared immediately, without waiting for a clock edge, and bpu_w_en SHALL be ignored.
REQ-021 While reset=0 and after reset release until the first write, every lookup SHALL miss, giving predicted_pc = current_pc + 4.
REQ-022 Tag and target fields need not be reset.
REQ-023 A reset asserted mid-operation SHALL discard all previously recorded entries.

Configuration
REQ-024 Macro BPU_BYPASS_EN, when defined: if bpu_w_en=1 and tag_pc and current_pc have equal index and equal tag in the same cycle, predicted_pc SHALL equal next_pc combinationally. This forwarding SHALL be suppressed while reset=0.
REQ-025 Without BPU_BYPASS_EN, no forwarding SHALL occur, and the lookup SHALL reflect table contents before the edge.

Verification
REQ-026 Reset: pulse reset=0, then hold reset=1 with current_pc=0x00000000 and no writes -> predicted_pc=0x00000004.
REQ-027 Write then overwrite: set bpu_w_en=1, tag_pc=0, next_pc=0xC0C0C0C0 for one edge, then next_pc=0xA5A5A5AC for one edge, with current_pc=0 -> predicted_pc=0xC0C0C0C0 after the first edge and 0xA5A5A5AC after the second.
REQ-028 Alias: with an entry for tag_pc=0x00000000 present, current_pc=0x00000100 (same index, different tag) -> predicted_pc=0x00000104. Then write tag_pc=0x100, next_pc=0x2000 -> current_pc=0 now misses (predicted_pc=0x4).
REQ-029 Wrap: current_pc=0xFFFFFFFC on a miss -> predicted_pc=0x00000000.
REQ-030 Reset mid-operation: with an entry for pc 0x40 to 0x1000 present, assert reset=0 between clock edges -> predicted_pc for current_pc=0x40 becomes 0x44 immediately.
REQ-031 Same-cycle write/read: bpu_w_en=1, tag_pc=current_pc=0x80, next_pc=0x3000 on an empty table -> predicted_pc before the edge is 0x3000 with BPU_BYPASS_EN and 0x84 without it; it is 0x3000 after the edge in both builds.
